// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory
// and buffers returned words with their PCs in a prefetch FIFO for decode.
//
// state | meaning
// BOOT  | out of reset, no requests yet
// RUN   | fetching, one request per cycle while FIFO space allows
// HALT  | EBREAK delivered, fetch stopped until a redirect
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_ren,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        fetch_ready
);

  localparam int          AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW     = AW + 1;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    // Space is reserved for the outstanding response, so a push never finds the FIFO full.
    occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue      = (state_q == RUN) && !redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));
    push       = inflight_q && (state_q == RUN) && !redirect_valid;
    pop        = (count_q != '0) && fetch_ready;

    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_valid) begin
      state_d    = RUN;
      pc_d       = {redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        pc_d     = pc_q + 32'd4;
        req_pc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     if (push && (imem_rdata == EBREAK)) state_d = HALT;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_ren    = issue;
  assign fetch_valid = (count_q != '0);
  assign fetch_instr = fifo_instr_q[rd_ptr_q];
  assign fetch_pc    = fifo_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed startup/redirect/EBREAK/wrap/reset scenarios
// plus a randomized run checked against a PC-sequence reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_ren;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] ebreak_addr = 32'hFFFF_FFFF;

  logic        o_valid, o_ren, hs;
  logic [31:0] o_pc, o_instr, o_addr;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_ren(imem_ren), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == ebreak_addr) return EBREAK;
    return 32'h0000_0013 + ((a >> 2) << 7);
  endfunction

  // Memory returns the word for the address presented in the previous cycle.
  always @(posedge clk) imem_rdata <= memf(imem_addr);

  task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    fetch_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    o_valid = fetch_valid;
    o_ren   = imem_ren;
    o_pc    = fetch_pc;
    o_instr = fetch_instr;
    o_addr  = imem_addr;
    hs      = fetch_valid & rdy;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", imem_addr, RESET_PC); end
    checks++; if (imem_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b want 0", imem_ren); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fetch_valid); end
    do_reset();
    #1;
    checks++; if (imem_ren !== 1'b0) begin errors++; $display("FAIL boot_ren got %b want 0", imem_ren); end
    tick(1'b0, 1'b0, '0);
    checks++; if (o_ren !== 1'b1 || o_addr !== RESET_PC) begin errors++; $display("FAIL startup_c1 ren %b addr %h want 1 %h", o_ren, o_addr, RESET_PC); end
    tick(1'b0, 1'b0, '0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL startup_c2 valid %b want 0", o_valid); end
    tick(1'b0, 1'b0, '0);
    checks++; if (o_valid !== 1'b1 || o_pc !== RESET_PC) begin errors++; $display("FAIL startup_c3 valid %b pc %h want 1 %h", o_valid, o_pc, RESET_PC); end
  endtask

  task automatic test_stream();
    logic [31:0] exp = RESET_PC;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, '0);
      if (cyc < 3) begin
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_early cyc %0d valid %b want 0", cyc, o_valid); end
      end else begin
        checks++; if (o_valid !== 1'b1 || o_pc !== exp || o_instr !== memf(exp)) begin
          errors++; $display("FAIL stream cyc %0d valid %b pc %h instr %h want 1 %h %h", cyc, o_valid, o_pc, o_instr, exp, memf(exp));
        end
        exp += 4;
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    logic [31:0] exp = RESET_PC;
    do_reset();
    repeat (10) begin
      tick(1'b0, 1'b0, '0);
      nreq += int'(o_ren);
    end
    checks++; if (nreq != DEPTH) begin errors++; $display("FAIL bp_requests got %0d want %0d", nreq, DEPTH); end
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, '0);
      checks++; if (o_valid !== 1'b1 || o_pc !== exp || o_instr !== memf(exp)) begin
        errors++; $display("FAIL bp_drain %0d valid %b pc %h want 1 %h", i, o_valid, o_pc, exp);
      end
      exp += 4;
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp = 32'h0000_0100;
    do_reset();
    repeat (4) tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 32'h0000_0103);
    tick(1'b1, 1'b0, '0);
    checks++; if (o_ren !== 1'b1 || o_addr !== 32'h100 || o_valid !== 1'b0) begin
      errors++; $display("FAIL redir_r1 ren %b addr %h valid %b want 1 100 0", o_ren, o_addr, o_valid);
    end
    tick(1'b1, 1'b0, '0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL redir_r2 valid %b want 0", o_valid); end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, '0);
      checks++; if (o_valid !== 1'b1 || o_pc !== exp || o_instr !== memf(exp)) begin
        errors++; $display("FAIL redir_stream %0d valid %b pc %h want 1 %h", i, o_valid, o_pc, exp);
      end
      exp += 4;
    end
  endtask

  task automatic test_ebreak();
    int seen = 0;
    logic [31:0] exp = RESET_PC;
    ebreak_addr = 32'h0000_0008;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      tick(1'b1, 1'b0, '0);
      if (hs) begin
        checks++; if (o_pc !== exp || o_instr !== memf(exp)) begin
          errors++; $display("FAIL ebreak_seq pc %h instr %h want %h %h", o_pc, o_instr, exp, memf(exp));
        end
        if (exp == 32'h8) begin
          checks++; if (o_instr !== 32'h0010_0073) begin errors++; $display("FAIL ebreak_word got %h want 00100073", o_instr); end
        end
        exp += 4;
        seen++;
      end
      if (cyc >= 6) begin
        checks++; if (o_ren !== 1'b0 || o_valid !== 1'b0) begin
          errors++; $display("FAIL halt_idle cyc %0d ren %b valid %b want 0 0", cyc, o_ren, o_valid);
        end
      end
    end
    checks++; if (seen != 3) begin errors++; $display("FAIL ebreak_count got %0d want 3", seen); end
    tick(1'b1, 1'b1, 32'h0000_0040);
    tick(1'b1, 1'b0, '0);
    checks++; if (o_ren !== 1'b1 || o_addr !== 32'h40 || o_valid !== 1'b0) begin
      errors++; $display("FAIL resume_r1 ren %b addr %h valid %b want 1 40 0", o_ren, o_addr, o_valid);
    end
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h40) begin
      errors++; $display("FAIL resume_r3 valid %b pc %h want 1 40", o_valid, o_pc);
    end
    ebreak_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q[$] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    int got = 0;
    do_reset();
    repeat (5) tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 10 && got < 3; i++) begin
      tick(1'b1, 1'b0, '0);
      if (hs) begin
        checks++; if (o_pc !== exp_q[got] || o_instr !== memf(exp_q[got])) begin
          errors++; $display("FAIL wrap %0d pc %h want %h", got, o_pc, exp_q[got]);
        end
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL wrap_timeout got %0d want 3", got); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (6) tick(1'b1, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (imem_ren !== 1'b0 || fetch_valid !== 1'b0 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL midrst ren %b valid %b addr %h want 0 0 %h", imem_ren, fetch_valid, imem_addr, RESET_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    tick(1'b1, 1'b0, '0);
    checks++; if (o_ren !== 1'b1 || o_addr !== RESET_PC) begin errors++; $display("FAIL midrst_c1 ren %b addr %h", o_ren, o_addr); end
    tick(1'b1, 1'b0, '0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_c2 valid %b want 0", o_valid); end
    tick(1'b1, 1'b0, '0);
    checks++; if (o_valid !== 1'b1 || o_pc !== RESET_PC) begin errors++; $display("FAIL midrst_c3 valid %b pc %h want 1 %h", o_valid, o_pc, RESET_PC); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] nxt = RESET_PC;
    logic [31:0] rpc;
    logic rdy, redir;
    int occ = 0;
    int total = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 24) == 0);
      rpc   = $urandom;
      tick(rdy, redir, rpc);
      checks++; if (o_addr !== nxt) begin errors++; $display("FAIL rnd_addr %0d got %h want %h", i, o_addr, nxt); end
      if (redir) begin
        checks++; if (o_ren !== 1'b0) begin errors++; $display("FAIL rnd_redir_ren %0d got %b want 0", i, o_ren); end
      end
      if (hs) begin
        checks++; if (o_pc !== exp_pc || o_instr !== memf(exp_pc)) begin
          errors++; $display("FAIL rnd_deliver %0d pc %h instr %h want %h %h", i, o_pc, o_instr, exp_pc, memf(exp_pc));
        end
        exp_pc += 4;
        total++;
      end
      occ = occ + int'(o_ren) - int'(hs);
      checks++; if (occ > DEPTH || occ < 0) begin errors++; $display("FAIL rnd_occupancy %0d got %0d want 0..%0d", i, occ, DEPTH); end
      if (o_ren) nxt += 4;
      if (redir) begin
        exp_pc = {rpc[31:2], 2'b00};
        nxt    = exp_pc;
        occ    = 0;
      end
    end
    checks++; if (total < 100) begin errors++; $display("FAIL rnd_progress got %0d want >= 100", total); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_ebreak();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
